// File: rtl/gpu_inst_pkg.sv
// Shared definitions for the GPU instruction word, used by the host-side
// packer and by the decode stage.
package gpu_inst_pkg;

    localparam int INST_W         = 82;
    localparam int HOST_W         = 16;
    localparam int WORDS_PER_INST = 6;

    localparam int COORD_MSB = 81;
    localparam int COORD_LSB = 34;
    localparam int ALPHA_MSB = 33;
    localparam int ALPHA_LSB = 30;
    localparam int TEX_MSB   = 29;
    localparam int TEX_LSB   = 28;
    localparam int COLOR_MSB = 27;
    localparam int COLOR_LSB = 4;
    localparam int LAYER_BIT = 3;
    localparam int VERT_BIT  = 2;
    localparam int TYPE_BIT  = 1;
    localparam int FILL_BIT  = 0;

    typedef struct packed {
        logic [47:0] coordinates;
        logic [3:0]  alpha_val;
        logic [1:0]  texture_code;
        logic [23:0] color_code;
        logic        layer_num;
        logic        vertice_num;
        logic        inst_type;
        logic        fill_type;
    } inst_t;

endpackage

// File: rtl/inst_packer.sv
// Packs six 16-bit host command words into one 82-bit instruction and
// pushes it into the instruction FIFO through a one-entry output buffer.
// Word 0 carries only the top two instruction bits; its upper 14 bits are
// reserved. Word 5 goes straight into the buffer, so the collector only
// holds instruction bits [81:16].
module inst_packer
    import gpu_inst_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [HOST_W-1:0]  host_data,
    input  logic               host_valid,
    input  logic               host_start,
    output logic               host_ready,
    input  logic               fifo_full,
    output logic               fifo_w_enable,
    output logic [INST_W-1:0]  fifo_w_data,
    output logic               sync_err,
    output logic               busy,
    output logic [CNT_W-1:0]   inst_count
);

    localparam logic [2:0] LAST_WORD = 3'(WORDS_PER_INST - 1);

    logic [2:0]               word_cnt;
    logic [INST_W-1:HOST_W]   asm_q;
    inst_t                    out_buf;
    logic                     out_full;
    logic                     accept;
    logic                     load;

    assign host_ready    = !(word_cnt == LAST_WORD && out_full && fifo_full);
    assign accept        = host_valid && host_ready;
    assign load          = accept && !host_start && word_cnt == LAST_WORD;
    assign fifo_w_enable = out_full && !fifo_full;
    assign fifo_w_data   = out_buf;
    assign busy          = (word_cnt != 3'd0) || out_full;

    // Collector: framing checks, word slotting and the sync_err pulse.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            word_cnt <= 3'd0;
            asm_q    <= '0;
            sync_err <= 1'b0;
        end else begin
            sync_err <= 1'b0;
            if (accept) begin
                if (host_start) begin
                    // A start mid-instruction abandons the partial one.
                    sync_err            <= (word_cnt != 3'd0);
                    asm_q[INST_W-1:80]  <= host_data[1:0];
                    word_cnt            <= 3'd1;
                end else if (word_cnt == 3'd0) begin
                    sync_err <= 1'b1;
                end else begin
                    case (word_cnt)
                        3'd1:    asm_q[79:64] <= host_data;
                        3'd2:    asm_q[63:48] <= host_data;
                        3'd3:    asm_q[47:32] <= host_data;
                        3'd4:    asm_q[31:16] <= host_data;
                        default: ;
                    endcase
                    word_cnt <= (word_cnt == LAST_WORD) ? 3'd0 : word_cnt + 3'd1;
                end
            end
        end
    end

    // Output buffer: a new load wins over the drain of the previous entry.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out_buf  <= '0;
            out_full <= 1'b0;
        end else if (load) begin
            out_buf  <= inst_t'({asm_q, host_data});
            out_full <= 1'b1;
        end else if (fifo_w_enable) begin
            out_full <= 1'b0;
        end
    end

    // Count of instructions handed to the FIFO, wrapping naturally.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            inst_count <= '0;
        end else if (fifo_w_enable) begin
            inst_count <= inst_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_inst_packer.sv
// Directed bench for inst_packer with a word-level reference model and a
// per-cycle compare of every output.
module tb_inst_packer;
    import gpu_inst_pkg::*;

    localparam int CNT_W = 4;

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic [15:0]       host_data = '0;
    logic              host_valid = 1'b0;
    logic              host_start = 1'b0;
    logic              host_ready;
    logic              fifo_full = 1'b0;
    logic              fifo_w_enable;
    logic [81:0]       fifo_w_data;
    logic              sync_err;
    logic              busy;
    logic [CNT_W-1:0]  inst_count;

    inst_packer #(.CNT_W(CNT_W)) dut (
        .clk(clk), .n_rst(n_rst), .host_data(host_data), .host_valid(host_valid),
        .host_start(host_start), .host_ready(host_ready), .fifo_full(fifo_full),
        .fifo_w_enable(fifo_w_enable), .fifo_w_data(fifo_w_data), .sync_err(sync_err),
        .busy(busy), .inst_count(inst_count)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int se_cnt = 0;
    int stall_cnt = 0;
    logic [81:0] wr_data [$];
    int          wr_cyc  [$];

    task automatic check(input string nm, input logic [81:0] act, input logic [81:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference model: an instruction is the last six words shifted together.
    logic [95:0]      m_acc = '0;
    int               m_cnt = 0;
    logic             m_full = 1'b0;
    logic [81:0]      m_buf = '0;
    logic             m_serr = 1'b0;
    logic [CNT_W-1:0] m_count = '0;

    always @(posedge clk or negedge n_rst) begin : model
        logic [95:0]      acc;
        int               cnt;
        logic             full, serr, rdy;
        logic [81:0]      bufv;
        logic [CNT_W-1:0] count;
        if (!n_rst) begin
            m_acc <= '0; m_cnt <= 0; m_full <= 1'b0; m_buf <= '0; m_serr <= 1'b0; m_count <= '0;
        end else begin
            acc = m_acc; cnt = m_cnt; full = m_full; bufv = m_buf; count = m_count; serr = 1'b0;
            rdy = !(cnt == 5 && full && fifo_full);
            if (full && !fifo_full) begin
                count = count + 1'b1;
                full = 1'b0;
            end
            if (host_valid && rdy) begin
                if (host_start) begin
                    serr = (cnt != 0);
                    acc = {80'b0, host_data};
                    cnt = 1;
                end else if (cnt == 0) begin
                    serr = 1'b1;
                end else begin
                    acc = {acc[79:0], host_data};
                    cnt = cnt + 1;
                    if (cnt == 6) begin
                        bufv = acc[81:0];
                        full = 1'b1;
                        cnt = 0;
                    end
                end
            end
            m_acc <= acc; m_cnt <= cnt; m_full <= full; m_buf <= bufv;
            m_serr <= serr; m_count <= count;
        end
    end

    logic e_ready, e_wen, e_busy;
    assign e_ready = !(m_cnt == 5 && m_full && fifo_full);
    assign e_wen   = m_full && !fifo_full;
    assign e_busy  = (m_cnt != 0) || m_full;

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle compare of all outputs against the model, plus a write log.
    always @(negedge clk) begin
        check("host_ready", 82'(host_ready), 82'(e_ready));
        check("fifo_w_enable", 82'(fifo_w_enable), 82'(e_wen));
        check("busy", 82'(busy), 82'(e_busy));
        check("sync_err", 82'(sync_err), 82'(m_serr));
        check("inst_count", 82'(inst_count), 82'(m_count));
        if (m_full) check("fifo_w_data", fifo_w_data, m_buf);
        if (fifo_w_enable) begin
            wr_data.push_back(fifo_w_data);
            wr_cyc.push_back(cyc);
        end
        if (sync_err) se_cnt <= se_cnt + 1;
        if (host_valid && !host_ready) stall_cnt <= stall_cnt + 1;
    end

    task automatic send(input logic [15:0] d, input logic s);
        bit done = 1'b0;
        host_valid = 1'b1; host_data = d; host_start = s;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = host_ready;
            @(posedge clk); #1;
        end
        if (!done) begin
            n_total++;
            $display("FAIL send_timeout: word %h not accepted within 50 cycles", d);
        end
    endtask

    task automatic send_inst(input logic [95:0] v);
        for (int k = 0; k < 6; k++) send(v[95-16*k -: 16], k == 0);
    endtask

    task automatic idle(input int n);
        host_valid = 1'b0; host_start = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    localparam logic [95:0] INST_A = 96'h0002_1234_5678_9ABC_DEF0_1357;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int nw, ns;
        logic [95:0] v;
        logic [81:0] d;
        logic [95:0] inst_b;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 82'(host_ready), 82'd1);
        check("rst_wen", 82'(fifo_w_enable), 82'd0);
        check("rst_busy", 82'(busy), 82'd0);
        check("rst_count", 82'(inst_count), 82'd0);
        check("rst_sync_err", 82'(sync_err), 82'd0);
        n_rst = 1'b1;
        idle(2);

        // Reset mid-instruction discards the partial words silently
        send(16'h0002, 1'b1); send(16'h1111, 1'b0); send(16'h2222, 1'b0);
        host_valid = 1'b0;
        check("pre_rst_busy", 82'(busy), 82'd1);
        n_rst = 1'b0;
        #2;
        check("mid_rst_busy", 82'(busy), 82'd0);
        check("mid_rst_count", 82'(inst_count), 82'd0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        idle(3);
        check("post_rst_writes", 82'(wr_data.size()), 82'd0);
        check("post_rst_sync_err", 82'(se_cnt), 82'd0);

        // Single instruction with field decode
        send_inst(INST_A);
        idle(3);
        check("single_writes", 82'(wr_data.size()), 82'd1);
        d = (wr_data.size() > 0) ? wr_data[0] : '0;
        check("single_data", d, 82'h2_1234_5678_9ABC_DEF0_1357);
        check("single_count", 82'(inst_count), 82'd1);
        check("f_coord", 82'(d[COORD_MSB:COORD_LSB]), 82'h848D159E26AF);
        check("f_alpha", 82'(d[ALPHA_MSB:ALPHA_LSB]), 82'd3);
        check("f_tex", 82'(d[TEX_MSB:TEX_LSB]), 82'd1);
        check("f_color", 82'(d[COLOR_MSB:COLOR_LSB]), 82'hEF0135);
        check("f_bits", 82'({d[LAYER_BIT], d[VERT_BIT], d[TYPE_BIT], d[FILL_BIT]}), 82'b0111);

        // Back-to-back streaming of 10 instructions
        nw = wr_data.size();
        stall_cnt = 0;
        for (int n = 0; n < 10; n++) begin
            v = {16'h0001 + 16'(n), 16'hA000 + 16'(n), 16'hB000 + 16'(n),
                 16'hC000 + 16'(n), 16'hD000 + 16'(n), 16'hE000 + 16'(n)};
            send_inst(v);
        end
        idle(4);
        check("stream_writes", 82'(wr_data.size() - nw), 82'd10);
        check("stream_stalls", 82'(stall_cnt), 82'd0);
        for (int n = 1; n < 10 && nw + n < wr_cyc.size(); n++)
            check("stream_spacing", 82'(wr_cyc[nw+n] - wr_cyc[nw+n-1]), 82'd6);
        for (int n = 0; n < 10 && nw + n < wr_data.size(); n++) begin
            v = {16'h0001 + 16'(n), 16'hA000 + 16'(n), 16'hB000 + 16'(n),
                 16'hC000 + 16'(n), 16'hD000 + 16'(n), 16'hE000 + 16'(n)};
            check("stream_data", wr_data[nw+n], v[81:0]);
        end
        check("stream_count", 82'(inst_count), 82'd11);

        // Back-pressure: buffer one instruction, stall on word 5 of the next
        nw = wr_data.size();
        inst_b = 96'h0003_4444_5555_6666_7777_8888;
        fifo_full = 1'b1;
        send_inst(96'h0001_0101_0202_0303_0404_0505);
        for (int k = 0; k < 5; k++) send(inst_b[95-16*k -: 16], k == 0);
        host_valid = 1'b1; host_data = inst_b[15:0]; host_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("bp_ready_low", 82'(host_ready), 82'd0);
        check("bp_no_write", 82'(wr_data.size() - nw), 82'd0);
        fifo_full = 1'b0;
        #1;
        check("bp_ready_rise", 82'(host_ready), 82'd1);
        check("bp_wen_rise", 82'(fifo_w_enable), 82'd1);
        send(inst_b[15:0], 1'b0);
        idle(4);
        check("bp_writes", 82'(wr_data.size() - nw), 82'd2);
        if (wr_data.size() >= nw + 2) begin
            check("bp_data0", wr_data[nw], 82'h1_0101_0202_0303_0404_0505);
            check("bp_data1", wr_data[nw+1], inst_b[81:0]);
            check("bp_spacing", 82'(wr_cyc[nw+1] - wr_cyc[nw]), 82'd1);
        end
        check("bp_count", 82'(inst_count), 82'd13);

        // Framing errors
        nw = wr_data.size();
        ns = se_cnt;
        send(16'h00AA, 1'b0);
        idle(3);
        check("drop_sync_err", 82'(se_cnt - ns), 82'd1);
        check("drop_busy", 82'(busy), 82'd0);
        send(16'h0003, 1'b1); send(16'hAAAA, 1'b0); send(16'hBBBB, 1'b0);
        send(16'h0001, 1'b1);
        send(16'h1111, 1'b0); send(16'h2222, 1'b0); send(16'h3333, 1'b0);
        send(16'h4444, 1'b0); send(16'h5555, 1'b0);
        idle(3);
        check("restart_sync_err", 82'(se_cnt - ns), 82'd2);
        check("restart_writes", 82'(wr_data.size() - nw), 82'd1);
        if (wr_data.size() > nw) check("restart_data", wr_data[nw], 82'h1_1111_2222_3333_4444_5555);
        check("restart_count", 82'(inst_count), 82'd14);

        // Counter wrap at 2^CNT_W
        send_inst(96'h0000_0000_0000_0000_0000_0001);
        send_inst(96'h0000_0000_0000_0000_0000_0002);
        idle(3);
        check("wrap_zero", 82'(inst_count), 82'd0);
        send_inst(96'h0000_0000_0000_0000_0000_0003);
        idle(3);
        check("wrap_one", 82'(inst_count), 82'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
